// File: rtl/axi_isolate_seq_pkg.sv
// axi_isolate_seq_pkg: command/state encodings and counter sizing for the isolation sequencer
package axi_isolate_seq_pkg;
  typedef enum logic [1:0] {CmdNop, CmdIsolate, CmdRelease, CmdResetCycle} cmd_e;
  typedef enum logic [2:0] {Connected, Isolating, Isolated, Resetting, Releasing} state_e;
  function automatic int cnt_width(int timeout_cycles, int rst_cycles);
    return $clog2((timeout_cycles > rst_cycles ? timeout_cycles : rst_cycles) + 1);
  endfunction
endpackage

// File: rtl/axi_isolate_seq_if.sv
// axi_isolate_seq_if: command handshake, per-port isolation handshake and status of the sequencer
//   cmd_valid/cmd_ready/cmd/port_mask : command channel from the control registers
//   isolate/isolated                  : to/from the per-port axi_isolate blocks
//   domain_rst/done/err/timeout/state : domain reset request and status
//   slave modport = sequencer side, master modport = environment side
interface axi_isolate_seq_if #(parameter int NumPorts = 2);
  import axi_isolate_seq_pkg::*;
  logic                cmd_valid;
  logic                cmd_ready;
  cmd_e                cmd;
  logic [NumPorts-1:0] port_mask;
  logic [NumPorts-1:0] isolate;
  logic [NumPorts-1:0] isolated;
  logic                domain_rst;
  logic                done;
  logic                err;
  logic                timeout;
  logic [2:0]          state;
  modport slave (input cmd_valid, cmd, port_mask, isolated,
                 output cmd_ready, isolate, domain_rst, done, err, timeout, state);
  modport master (output cmd_valid, cmd, port_mask, isolated,
                  input cmd_ready, isolate, domain_rst, done, err, timeout, state);
endinterface

// File: rtl/axi_isolate_seq_timer.sv
// axi_isolate_seq_timer: saturating up-counter with clear/enable and terminal-count compare
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i, en_i  : synchronous clear (wins over enable), count enable
//   term_i       : terminal count; tc_o is high while the count equals it
module axi_isolate_seq_timer #(
  parameter int CntWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] term_i,
  output logic                tc_o
);
  logic [CntWidth-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  assign tc_o = cnt_q == term_i;
endmodule

// File: rtl/axi_isolate_seq.sv
// axi_isolate_seq: sequences isolate/release/reset-cycle of a group of axi_isolate ports
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : slave modport of axi_isolate_seq_if (commands, isolation handshake, status)
module axi_isolate_seq
  import axi_isolate_seq_pkg::*;
#(
  parameter int NumPorts      = 2,
  parameter int TimeoutCycles = 1024,
  parameter int RstCycles     = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  axi_isolate_seq_if.slave  bus
);
  localparam int CntWidth = cnt_width(TimeoutCycles, RstCycles);
  state_e              state_q, state_d;
  logic [NumPorts-1:0] mask_q, mask_d, iso_q, iso_d;
  logic                drst_q, done_q, done_d, err_q, err_d, to_q, to_d;
  logic                rc_q, rc_d, fi_q, fi_d, ready_q;
  logic                acc, all_iso, none_iso, clr, en, tc;
  logic [CntWidth-1:0] term;
  assign acc      = bus.cmd_valid & ready_q;
  assign all_iso  = &(bus.isolated | ~mask_q);
  assign none_iso = ~|(bus.isolated & mask_q);
  assign en       = state_q == Isolating || state_q == Resetting;
  assign term     = state_q == Resetting ? CntWidth'(RstCycles - 1) : CntWidth'(TimeoutCycles - 1);
  axi_isolate_seq_timer #(.CntWidth(CntWidth)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .en_i  (en),
    .term_i(term),
    .tc_o  (tc)
  );
  // rc_q: sequence started as RESET_CYCLE; fi_q: Resetting was entered from Isolated
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    iso_d   = iso_q;
    to_d    = acc ? 1'b0 : to_q;
    rc_d    = rc_q;
    fi_d    = fi_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      Connected:
        if (acc) begin
          if (bus.cmd == CmdIsolate || bus.cmd == CmdResetCycle) begin
            state_d = Isolating;
            mask_d  = bus.port_mask;
            iso_d   = bus.port_mask;
            rc_d    = bus.cmd == CmdResetCycle;
            fi_d    = 1'b0;
            clr     = 1'b1;
          end else begin
            done_d = 1'b1;
            err_d  = bus.cmd == CmdRelease;
          end
        end
      Isolating:
        if (all_iso) begin
          state_d = rc_q ? Resetting : Isolated;
          done_d  = !rc_q;
          clr     = rc_q;
        end else if (tc) begin
          state_d = Releasing;
          iso_d   = '0;
          to_d    = 1'b1;
        end
      Isolated:
        if (acc) begin
          if (bus.cmd == CmdRelease) begin
            state_d = Releasing;
            iso_d   = '0;
          end else if (bus.cmd == CmdResetCycle) begin
            state_d = Resetting;
            fi_d    = 1'b1;
            clr     = 1'b1;
          end else begin
            done_d = 1'b1;
            err_d  = bus.cmd == CmdIsolate;
          end
        end
      Resetting:
        if (tc) begin
          state_d = fi_q ? Isolated : Releasing;
          done_d  = fi_q;
          iso_d   = fi_q ? iso_q : '0;
        end
      Releasing:
        if (none_iso) begin
          state_d = Connected;
          done_d  = 1'b1;
          err_d   = to_q;
        end
      default: state_d = Connected;
    endcase
  end
  // ready is withheld in the cycle done_o is high so done_o/err_o can never pulse back to back
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= Connected;
      mask_q  <= '0;
      iso_q   <= '0;
      drst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      rc_q    <= 1'b0;
      fi_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      iso_q   <= iso_d;
      drst_q  <= state_d == Resetting;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
      rc_q    <= rc_d;
      fi_q    <= fi_d;
      ready_q <= (state_d == Connected || state_d == Isolated) && !done_d;
    end
  assign bus.cmd_ready  = ready_q;
  assign bus.isolate    = iso_q;
  assign bus.domain_rst = drst_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.timeout    = to_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_axi_isolate_seq.sv
// tb_axi_isolate_seq: scoreboard bench for axi_isolate_seq with a behavioural port model
module tb_axi_isolate_seq;
  import axi_isolate_seq_pkg::*;
  localparam int T = 8;
  localparam int R = 4;
  typedef struct {
    bit         err;
    int         st;
    logic [1:0] iso;
    bit         to;
    int         rsts;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_isolate_seq_if #(.NumPorts(2)) bus();
  axi_isolate_seq #(.NumPorts(2), .TimeoutCycles(T), .RstCycles(R)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  bit         m_iso = 1'b0;
  logic [1:0] m_mask = '0;
  logic [1:0] stuck = '0;
  logic [1:0] iso_force = '0;
  bit         env_en = 1'b1;
  int         dly[2] = '{0, 0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Port model: each port's isolated follows isolate after dly cycles; stuck ports never rise
  initial begin
    int cnt[2];
    cnt = '{0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.isolated = '0;
        cnt = '{0, 0};
      end else if (!env_en) bus.isolated = iso_force;
      else
        for (int p = 0; p < 2; p++) begin
          if (bus.isolated[p] !== bus.isolate[p] && !(bus.isolate[p] && stuck[p])) begin
            if (cnt[p] >= dly[p]) begin
              bus.isolated[p] = bus.isolate[p];
              cnt[p] = 0;
            end else cnt[p]++;
          end else cnt[p] = 0;
        end
    end
  end
  // Monitor: every done pulse consumes one expected completion
  initial begin
    bit   prev;
    int   rc;
    exp_t e;
    prev = 1'b0;
    rc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        rc = 0;
      end else begin
        if (bus.err && !bus.done) chk("err_only_with_done", 32'(bus.done), 1);
        if (bus.done) begin
          chk("done_not_back_to_back", 32'(prev), 0);
          if (q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            chk("err", 32'(bus.err), 32'(e.err));
            chk("state", 32'(bus.state), e.st);
            chk("isolate", 32'(bus.isolate), 32'(e.iso));
            chk("timeout", 32'(bus.timeout), 32'(e.to));
            chk("rst_cycles", rc, e.rsts);
          end
          rc = 0;
        end
        if (bus.domain_rst) rc++;
        prev = bus.done;
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) chk("ready_wait", 0, 1);
  endtask
  // Reference: outcome of a command from the sequencer's abstract Connected/Isolated condition
  task automatic predict(input cmd_e c, input logic [1:0] m, input logic [1:0] s);
    exp_t e;
    e = '{err: 1'b0, st: 0, iso: 2'b00, to: 1'b0, rsts: 0};
    if (!m_iso) begin
      if (c == CmdRelease) e.err = 1'b1;
      else if (c == CmdIsolate || c == CmdResetCycle) begin
        if ((s & m) != 0) begin
          e.err = 1'b1;
          e.to = 1'b1;
        end else if (c == CmdIsolate) begin
          e.st = 2;
          e.iso = m;
          m_iso = 1'b1;
          m_mask = m;
        end else e.rsts = R;
      end
    end else begin
      e.st = 2;
      e.iso = m_mask;
      if (c == CmdIsolate) e.err = 1'b1;
      else if (c == CmdResetCycle) e.rsts = R;
      else if (c == CmdRelease) begin
        e.st = 0;
        e.iso = 2'b00;
        m_iso = 1'b0;
      end
    end
    q.push_back(e);
  endtask
  task automatic do_cmd(input cmd_e c, input logic [1:0] m, input logic [1:0] s, input bit push);
    wait_ready();
    stuck = s;
    dly[0] = $urandom_range(0, 3);
    dly[1] = $urandom_range(0, 3);
    if (push) predict(c, m, s);
    bus.cmd_valid = 1'b1;
    bus.cmd = c;
    bus.port_mask = m;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd = CmdNop;
    bus.port_mask = 2'($urandom);
  endtask
  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd = CmdNop;
    bus.port_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_isolate", 32'(bus.isolate), 0);
    chk("rst_domain_rst", 32'(bus.domain_rst), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(CmdIsolate, 2'b11, 2'b00, 1'b1);
    wait_ready();
    chk("isolate_held", 32'(bus.isolate), 3);
    do_cmd(CmdIsolate, 2'b01, 2'b00, 1'b1);
    chk("illegal_isolate_latency", 32'({bus.done, bus.err, bus.state}), 32'({2'b11, 3'd2}));
    do_cmd(CmdRelease, 2'b00, 2'b00, 1'b1);
    do_cmd(CmdRelease, 2'b10, 2'b00, 1'b1);
    chk("illegal_release_latency", 32'({bus.done, bus.err, bus.state}), 32'({2'b11, 3'd0}));
    do_cmd(CmdIsolate, 2'b01, 2'b01, 1'b1);
    repeat (T - 1) @(posedge clk);
    #1;
    chk("timeout_not_early", 32'(bus.timeout), 0);
    @(posedge clk);
    #1;
    chk("timeout_on_time", 32'(bus.timeout), 1);
    chk("timeout_releasing", 32'(bus.state), 4);
    chk("timeout_isolate_dropped", 32'(bus.isolate), 0);
    do_cmd(CmdNop, 2'b00, 2'b00, 1'b1);
    do_cmd(CmdResetCycle, 2'b11, 2'b00, 1'b1);
    do_cmd(CmdIsolate, 2'b10, 2'b00, 1'b1);
    do_cmd(CmdResetCycle, 2'b01, 2'b00, 1'b1);
    do_cmd(CmdRelease, 2'b00, 2'b00, 1'b1);
    wait_ready();
    iso_force = bus.isolated;
    env_en = 1'b0;
    do_cmd(CmdIsolate, 2'b01, 2'b00, 1'b1);
    repeat (T - 2) @(posedge clk);
    #1;
    iso_force = 2'b01;
    wait_ready();
    env_en = 1'b1;
    for (int i = 0; i < 60; i++)
      do_cmd(cmd_e'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00, 1'b1);
    wait_ready();
    if (m_iso) do_cmd(CmdRelease, 2'b00, 2'b00, 1'b1);
    do_cmd(CmdResetCycle, 2'b11, 2'b00, 1'b0);
    n = 0;
    while (!bus.domain_rst && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("domain_rst_seen", 32'(bus.domain_rst), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_domain_rst", 32'(bus.domain_rst), 0);
    chk("abort_isolate", 32'(bus.isolate), 0);
    chk("abort_state", 32'(bus.state), 0);
    q.delete();
    m_iso = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(CmdNop, 2'b00, 2'b00, 1'b1);
    do_cmd(CmdIsolate, 2'b10, 2'b00, 1'b1);
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
